ctr_seq: RTL and testbench
==========================

Name: ctr_seq

Overview:
- Parametrised control sequencer for the full-search block-matching array, generalising the fixed 24-cycle controller.
- It generates the memory write enables, PE enable and the PE control word for a configurable period schedule.
- It adds a start/done handshake, an internal init-length counter (no externally held init level), a per-run period count and a stall input that inserts bubbles.
- It sits between the top-level frame controller and the mem19198/mem448/mem20 buffers and the PE array.

Parameters:
- WORD_WIDTH, 8: pixel width.
- LANES, 4: pixels per input word; the raw bus is WORD_WIDTH*LANES bits.
- PERIOD, 24: cycles per search period; minimum 8.
- INIT_CYCLES, 73: length of the init phase in cycles; minimum 1.
- REF_LOAD, 4: phases 0..REF_LOAD-1 assert mem448 enable.
- CUR_SLOT, 5: the single phase that asserts mem20 enable; must satisfy REF_LOAD <= CUR_SLOT <= PERIOD-2.
- PE_START, 10: first phase of the PE word ramp; must satisfy REF_LOAD < PE_START < PERIOD.
- CW, 4: ctr_word width; must satisfy PERIOD-PE_START <= 2^CW-2.
- PCNT_W, 8: width of the period count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request pulse; sampled only in IDLE.
- num_periods  in  PCNT_W  periods per run, latched at accepted start; 0 is treated as 1.
- stall  in  1  bubble request, effective in RUN only.
- input_raw  in  WORD_WIDTH*LANES  raw pixel word.
- input_raw_saved  out  WORD_WIDTH*LANES  input_raw delayed 1 cycle.
- ctr_word  out  CW  PE control word.
- mem19198_en_input  out  1  search-window memory write enable.
- mem448_en_input  out  1  reference memory write enable.
- mem20_en_input  out  1  current-row memory write enable.
- mem_init_mode  out  1  memories in init/fill mode.
- en_pe  out  1  PE array enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at run completion.
- period_cnt  out  PCNT_W  index of the current period.

Behaviour:
- Reset: asynchronous, active-high. All outputs, including input_raw_saved, go to 0; state goes to IDLE and all counters clear.
- A reset assertion mid-run aborts immediately. The block takes no action after release until a new start.
- Output alignment: all outputs are registered and aligned with the state and phase. Registers load the decode of the next state/phase, so the cycle in which the FSM is at (state, ph) shows exactly that decode.
- Decode of each state:
  - IDLE: all control outputs 0, busy=0.
  - INIT: lasts INIT_CYCLES cycles (init_cnt 0..INIT_CYCLES-1). Outputs: mem19198_en_input=1, mem_init_mode=1, others 0.
- RUN: phase counter ph runs 0..PERIOD-1 and wraps. period_cnt increments on each wrap.
- RUN decode by phase:
  - ph=0: ctr_word=all-ones, en_pe=1, mem448_en_input=1.
  - ph=1: ctr_word=0, en_pe=1, mem448_en_input=1.
  - ph 2..REF_LOAD-1: mem448_en_input=1, all else 0.
  - ph REF_LOAD..PERIOD-2: mem19198_en_input=1.
  - ph=CUR_SLOT: mem20_en_input=1 in addition.
  - ph PE_START..PERIOD-1: ctr_word=ph-PE_START+1, en_pe=1.
  - ph=PERIOD-1: mem19198_en_input=0.
  - ctr_word is 0 wherever not specified.
- First-period exception (period_cnt=0):
  - ph=0: ctr_word=0, en_pe=0, mem_init_mode=1.
  - ph=1: en_pe=0.
- DRAIN: one cycle after the last period's ph=PERIOD-1. Outputs: ctr_word=all-ones, en_pe=1 (final flush), done=1, memory enables 0. The next state is IDLE.
- Transitions:
  - IDLE goes to INIT on start=1.
  - INIT goes to RUN ph=0, period_cnt=0, after its last cycle.
  - RUN goes to DRAIN after ph=PERIOD-1 when period_cnt equals the latched count minus 1.
  - DRAIN goes to IDLE.
- start: ignored while busy. A start in the DRAIN cycle is also ignored.
- Stall:
  - When stall=1 at a rising edge while in RUN (including the edge that would leave RUN), the following cycle is a bubble: all control outputs are 0 and ph, period_cnt and the state hold.
  - Consecutive stall cycles extend the bubble.
  - The cycle after the first edge with stall=0 resumes with the decode of the phase that was pending.
  - stall is ignored in IDLE, INIT and DRAIN.
- Width rules: ph width is clog2(PERIOD). period_cnt wraps never within a run, since the latched count is at most 2^PCNT_W-1.

Test Plan:
- Reset/idle: assert rst mid-INIT -> all outputs 0 asynchronously. After release with no start: busy=0 and outputs stay 0 for 100 cycles.
- Default run, num_periods=1:
  - Start -> 73 INIT cycles with mem19198_en_input=1 and mem_init_mode=1.
  - First period: ph0 ctr_word=0, en_pe=0; ph2-3 mem448 only; ph5 mem20=1; ph10..23 ctr_word=1..14 with en_pe=1; ph23 mem19198=0.
  - Then the DRAIN cycle: ctr_word=15, en_pe=1, done=1. Then IDLE.
  - Total busy cycles = 73+24+1 = 98.
- Multi-period, num_periods=3: second and third periods start ph0 with ctr_word=15, en_pe=1, mem_init_mode=0. period_cnt shows 0,1,2. done appears exactly once, 98+48 cycles after busy rises.
- Stall: assert stall for 3 edges at ph=12 of period 1 -> 3 bubble cycles with all controls 0, then ctr_word=4 (phase 13) resumes. done is delayed by 3 cycles.
- Boundary:
  - num_periods=0 behaves as 1.
  - start held high throughout -> back-to-back runs, each separated by one IDLE cycle.
  - start pulsed during RUN -> ignored.
- Parametrised instance PERIOD=16, PE_START=4, REF_LOAD=2, CUR_SLOT=3, INIT_CYCLES=5, CW=4 -> ramp ctr_word=1..12 at ph4..15. input_raw_saved equals input_raw delayed exactly 1 cycle throughout.

Source files
------------

// File: rtl/ctr_seq_if.sv
// Control/data bundle between the frame controller and the block-matching sequencer.
interface ctr_seq_if #(
  parameter int WORD_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int CW         = 4,
  parameter int PCNT_W     = 8
);
  logic                          start;
  logic [PCNT_W-1:0]             num_periods;
  logic                          stall;
  logic [WORD_WIDTH*LANES-1:0]   input_raw;
  logic [WORD_WIDTH*LANES-1:0]   input_raw_saved;
  logic [CW-1:0]                 ctr_word;
  logic                          mem19198_en_input;
  logic                          mem448_en_input;
  logic                          mem20_en_input;
  logic                          mem_init_mode;
  logic                          en_pe;
  logic                          busy;
  logic                          done;
  logic [PCNT_W-1:0]             period_cnt;

  modport master (
    output start, num_periods, stall, input_raw,
    input  input_raw_saved, ctr_word, mem19198_en_input, mem448_en_input,
           mem20_en_input, mem_init_mode, en_pe, busy, done, period_cnt
  );

  modport slave (
    input  start, num_periods, stall, input_raw,
    output input_raw_saved, ctr_word, mem19198_en_input, mem448_en_input,
           mem20_en_input, mem_init_mode, en_pe, busy, done, period_cnt
  );
endinterface

// File: rtl/ctr_seq.sv
// Block-matching control sequencer: IDLE -> INIT -> RUN (N periods) -> DRAIN, start/done handshake.
// All outputs registered from the next-state decode; stall in RUN inserts all-zero bubble cycles.
module ctr_seq #(
  parameter int WORD_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int PERIOD      = 24,
  parameter int INIT_CYCLES = 73,
  parameter int REF_LOAD    = 4,
  parameter int CUR_SLOT    = 5,
  parameter int PE_START    = 10,
  parameter int CW          = 4,
  parameter int PCNT_W      = 8
) (
  input logic       clk,
  input logic       rst,
  ctr_seq_if.slave  bus
);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int DW = WORD_WIDTH * LANES;

  localparam logic [PW-1:0] PH_LAST   = PW'(PERIOD - 1);
  localparam logic [PW-1:0] REF_PH    = PW'(REF_LOAD);
  localparam logic [PW-1:0] CUR_PH    = PW'(CUR_SLOT);
  localparam logic [PW-1:0] PE_PH     = PW'(PE_START);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       init_cnt_q, init_cnt_d;
  logic [PW-1:0]       ph_q, ph_d;
  logic [PCNT_W-1:0]   period_cnt_q, period_cnt_d;
  logic [PCNT_W-1:0]   num_q, num_d;
  logic                bubble;
  logic                first;
  logic [PW-1:0]       ramp_ph;

  logic [DW-1:0]       input_raw_saved_q, input_raw_saved_d;
  logic [CW-1:0]       ctr_word_q, ctr_word_d;
  logic                mem19198_q, mem19198_d;
  logic                mem448_q, mem448_d;
  logic                mem20_q, mem20_d;
  logic                init_mode_q, init_mode_d;
  logic                en_pe_q, en_pe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    ph_d         = ph_q;
    period_cnt_d = period_cnt_q;
    num_d        = num_q;
    bubble       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_INIT;
          init_cnt_d   = '0;
          ph_d         = '0;
          period_cnt_d = '0;
          num_d        = (bus.num_periods == '0) ? PCNT_W'(1) : bus.num_periods;
        end
      end
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d      = S_RUN;
          ph_d         = '0;
          period_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      S_RUN: begin
        // A stalled edge freezes everything so the pending phase is replayed afterwards.
        if (bus.stall) begin
          bubble = 1'b1;
        end else if (ph_q == PH_LAST) begin
          if (period_cnt_q == num_q - PCNT_W'(1)) begin
            state_d = S_DRAIN;
          end else begin
            ph_d         = '0;
            period_cnt_d = period_cnt_q + PCNT_W'(1);
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_DRAIN: begin
        state_d      = S_IDLE;
        period_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    input_raw_saved_d = bus.input_raw;
    ctr_word_d        = '0;
    mem19198_d        = 1'b0;
    mem448_d          = 1'b0;
    mem20_d           = 1'b0;
    init_mode_d       = 1'b0;
    en_pe_d           = 1'b0;
    done_d            = 1'b0;
    busy_d            = (state_d != S_IDLE);
    first             = (period_cnt_d == '0);
    ramp_ph           = ph_d - PE_PH + PW'(1);
    case (state_d)
      S_INIT: begin
        mem19198_d  = 1'b1;
        init_mode_d = 1'b1;
      end
      S_RUN: begin
        if (!bubble) begin
          if (ph_d < REF_PH) mem448_d = 1'b1;
          else if (ph_d != PH_LAST) mem19198_d = 1'b1;
          if (ph_d == CUR_PH) mem20_d = 1'b1;
          // ph0 closes the previous period's PE pass, except in the first period.
          if (ph_d == '0) begin
            mem448_d    = 1'b1;
            ctr_word_d  = first ? '0 : '1;
            en_pe_d     = !first;
            init_mode_d = first;
          end else if (ph_d == PW'(1)) begin
            mem448_d = 1'b1;
            en_pe_d  = !first;
          end else if (ph_d >= PE_PH) begin
            ctr_word_d = CW'(ramp_ph);
            en_pe_d    = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        ctr_word_d = '1;
        en_pe_d    = 1'b1;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      init_cnt_q        <= '0;
      ph_q              <= '0;
      period_cnt_q      <= '0;
      num_q             <= '0;
      input_raw_saved_q <= '0;
      ctr_word_q        <= '0;
      mem19198_q        <= 1'b0;
      mem448_q          <= 1'b0;
      mem20_q           <= 1'b0;
      init_mode_q       <= 1'b0;
      en_pe_q           <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      init_cnt_q        <= init_cnt_d;
      ph_q              <= ph_d;
      period_cnt_q      <= period_cnt_d;
      num_q             <= num_d;
      input_raw_saved_q <= input_raw_saved_d;
      ctr_word_q        <= ctr_word_d;
      mem19198_q        <= mem19198_d;
      mem448_q          <= mem448_d;
      mem20_q           <= mem20_d;
      init_mode_q       <= init_mode_d;
      en_pe_q           <= en_pe_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
    end
  end

  assign bus.input_raw_saved   = input_raw_saved_q;
  assign bus.ctr_word          = ctr_word_q;
  assign bus.mem19198_en_input = mem19198_q;
  assign bus.mem448_en_input   = mem448_q;
  assign bus.mem20_en_input    = mem20_q;
  assign bus.mem_init_mode     = init_mode_q;
  assign bus.en_pe             = en_pe_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.period_cnt        = period_cnt_q;
endmodule

// File: tb/tb_ctr_seq.sv
// Directed bench for ctr_seq: default instance plus a short-period instance.
module tb_ctr_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctr_seq_if #(.WORD_WIDTH(8), .LANES(4), .CW(4), .PCNT_W(8)) a_bus ();
  ctr_seq_if #(.WORD_WIDTH(8), .LANES(4), .CW(4), .PCNT_W(8)) b_bus ();

  ctr_seq u_a (.clk(clk), .rst(rst), .bus(a_bus));

  ctr_seq #(.PERIOD(16), .PE_START(4), .REF_LOAD(2), .CUR_SLOT(3),
            .INIT_CYCLES(5), .CW(4)) u_b (.clk(clk), .rst(rst), .bus(b_bus));

  int n_chk = 0;
  int n_err = 0;
  int a_busy_cnt = 0;
  int a_done_cnt = 0;

  // {ctr_word, mem19198, mem448, mem20, en_pe} per phase
  logic [7:0] tbl_a [24] = '{8'hF5, 8'h05, 8'h04, 8'h04, 8'h08, 8'h0A, 8'h08, 8'h08,
                             8'h08, 8'h08, 8'h19, 8'h29, 8'h39, 8'h49, 8'h59, 8'h69,
                             8'h79, 8'h89, 8'h99, 8'hA9, 8'hB9, 8'hC9, 8'hD9, 8'hE1};
  logic [7:0] tbl_b [16] = '{8'hF5, 8'h05, 8'h08, 8'h0A, 8'h19, 8'h29, 8'h39, 8'h49,
                             8'h59, 8'h69, 8'h79, 8'h89, 8'h99, 8'hA9, 8'hB9, 8'hC1};

  always @(negedge clk) begin
    if (a_bus.busy) a_busy_cnt++;
    if (a_bus.done) a_done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
    end
  endtask

  // {ctr_word, mem19198, mem448, mem20, en_pe, mem_init_mode, busy, done}
  function automatic logic [10:0] a_vec();
    return {a_bus.ctr_word, a_bus.mem19198_en_input, a_bus.mem448_en_input,
            a_bus.mem20_en_input, a_bus.en_pe, a_bus.mem_init_mode, a_bus.busy, a_bus.done};
  endfunction

  function automatic logic [10:0] b_vec();
    return {b_bus.ctr_word, b_bus.mem19198_en_input, b_bus.mem448_en_input,
            b_bus.mem20_en_input, b_bus.en_pe, b_bus.mem_init_mode, b_bus.busy, b_bus.done};
  endfunction

  function automatic logic [10:0] run_exp(input logic [7:0] e, input int p, input int ph);
    logic [10:0] v;
    v = {e, 3'b010};
    if (p == 0 && ph == 0) v = {4'h0, e[3:1], 1'b0, 3'b110};
    if (p == 0 && ph == 1) v[3] = 1'b0;
    return v;
  endfunction

  task automatic do_run(input logic [7:0] np, input int nper, input int st_per,
                        input int st_ph, input int st_len, input string tag);
    int b0, d0;
    b0 = a_busy_cnt;
    d0 = a_done_cnt;
    a_bus.num_periods = np;
    a_bus.start = 1'b1;
    @(negedge clk);
    a_bus.start = 1'b0;
    for (int i = 0; i < 73; i++) begin
      chk({tag, "_init"}, a_vec(), {4'h0, 4'b1000, 3'b110});
      @(negedge clk);
    end
    for (int p = 0; p < nper; p++) begin
      for (int ph = 0; ph < 24; ph++) begin
        chk({tag, "_run"}, a_vec(), run_exp(tbl_a[ph], p, ph));
        chk({tag, "_pcnt"}, a_bus.period_cnt, p);
        a_bus.start = (p == 1 && ph == 3);
        if (p == st_per && ph == st_ph) begin
          a_bus.stall = 1'b1;
          repeat (st_len) begin
            @(negedge clk);
            chk({tag, "_bubble"}, a_vec(), 11'b000_0000_0010);
            chk({tag, "_bub_pcnt"}, a_bus.period_cnt, p);
          end
          a_bus.stall = 1'b0;
        end
        @(negedge clk);
      end
    end
    chk({tag, "_drain"}, a_vec(), {4'hF, 4'b0001, 3'b011});
    a_bus.start = 1'b1;
    @(negedge clk);
    a_bus.start = 1'b0;
    chk({tag, "_idle1"}, a_vec(), 11'd0);
    @(negedge clk);
    chk({tag, "_idle2"}, a_vec(), 11'd0);
    chk({tag, "_busy_len"}, a_busy_cnt - b0, 73 + 24 * nper + 1 + ((st_per >= 0) ? st_len : 0));
    chk({tag, "_done_cnt"}, a_done_cnt - d0, 1);
  endtask

  initial begin
    logic got;
    a_bus.start = 1'b0; a_bus.stall = 1'b0; a_bus.num_periods = 8'd1;
    a_bus.input_raw = 32'hDEAD_BEEF;
    b_bus.start = 1'b0; b_bus.stall = 1'b0; b_bus.num_periods = 8'd1;
    b_bus.input_raw = 32'h1234_5678;

    repeat (3) @(negedge clk);
    chk("rst_vec", a_vec(), 11'd0);
    chk("rst_raw", a_bus.input_raw_saved, 32'd0);
    chk("rst_pcnt", a_bus.period_cnt, 32'd0);
    chk("rst_b_vec", b_vec(), 11'd0);
    rst = 1'b0;

    // abort mid-INIT with an asynchronous reset
    a_bus.start = 1'b1;
    @(negedge clk);
    a_bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_init", a_vec(), {4'h0, 4'b1000, 3'b110});
    #2 rst = 1'b1;
    #1;
    chk("async_vec", a_vec(), 11'd0);
    chk("async_raw", a_bus.input_raw_saved, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_quiet", a_vec(), 11'd0);
    end

    do_run(8'd1, 1, -1, 0, 0, "np1");
    do_run(8'd3, 3, -1, 0, 0, "np3");
    do_run(8'd0, 1, -1, 0, 0, "np0");
    do_run(8'd2, 2, 1, 12, 3, "stall");

    // start held high: runs separated by a single IDLE cycle
    a_bus.num_periods = 8'd1;
    a_bus.start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (a_bus.done) got = 1'b1;
    end
    chk("held_done1", got, 1);
    @(negedge clk);
    chk("held_gap", a_bus.busy, 0);
    @(negedge clk);
    chk("held_restart", a_vec(), {4'h0, 4'b1000, 3'b110});
    a_bus.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (a_bus.done) got = 1'b1;
    end
    chk("held_done2", got, 1);
    @(negedge clk);
    chk("held_end", a_bus.busy, 0);

    // short-period instance with a 1-cycle input_raw delay check every cycle
    b_bus.num_periods = 8'd1;
    b_bus.start = 1'b1;
    b_bus.input_raw = $urandom;
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      b_bus.start = 1'b0;
      chk("b_raw", b_bus.input_raw_saved, b_bus.input_raw);
      if (c < 5) chk("b_init", b_vec(), {4'h0, 4'b1000, 3'b110});
      else if (c < 21) chk("b_run", b_vec(), run_exp(tbl_b[c - 5], 0, c - 5));
      else if (c == 21) chk("b_drain", b_vec(), {4'hF, 4'b0001, 3'b011});
      else chk("b_idle", b_vec(), 11'd0);
      b_bus.input_raw = $urandom;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
